// File: rtl/channel_decimator.sv
// channel_decimator: averages DECIM interleaved frames per channel and writes one frame to the channel buffer
module channel_decimator #(
  parameter int CHANNELS = 128,
  parameter int DECIM    = 4,
  parameter int HOLDOFF  = CHANNELS + 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        s_valid,
  output logic        s_ready,
  input  logic        s_first,
  input  logic [15:0] s_data,
  output logic        en,
  output logic [15:0] data_out,
  output logic        frame_done,
  output logic        sync_err
);
  function automatic int clogb2(input int v);
    int r;
    r = 0;
    while (v > 0) begin
      r++;
      v = v >> 1;
    end
    return r;
  endfunction

  localparam int SH    = clogb2(DECIM - 1);
  localparam int ACC_W = 16 + SH;
  localparam int CW    = clogb2(CHANNELS - 1);
  localparam int CWI   = (CW > 0) ? CW : 1;
  localparam int FWI   = (SH > 0) ? SH : 1;
  localparam int HW    = clogb2(HOLDOFF);
  localparam int HWI   = (HW > 0) ? HW : 1;
  localparam int RND   = (1 << SH) >> 1;

  typedef enum logic [1:0] {ACCUM, EMIT, HOLD} state_t;
  // With DECIM=1 every frame is emitted directly, so the idle state is EMIT
  localparam state_t ST0 = (DECIM == 1) ? EMIT : ACCUM;

  state_t                   r_state, w_state_nxt, w_st;
  logic [CWI-1:0]           r_ch, w_ch;
  logic [FWI-1:0]           r_frm, w_frm;
  logic [HWI-1:0]           r_hold;
  logic                     r_live;
  logic signed [ACC_W-1:0]  r_acc [CHANNELS];
  logic signed [ACC_W-1:0]  w_ext, w_base, w_sum;
  logic signed [31:0]       w_q;
  logic [15:0]              w_out;
  logic                     w_acc, w_resync, w_ch_last, w_frm_last, w_emit;

  assign s_ready    = r_live && (r_state != HOLD);
  assign w_acc      = s_valid && s_ready;
  // A frame marker away from channel 0 restarts the frame with this sample as ch0/frm0
  assign w_resync   = s_first && (r_ch != '0);
  assign w_st       = w_resync ? ST0 : r_state;
  assign w_ch       = w_resync ? '0 : r_ch;
  assign w_frm      = w_resync ? '0 : r_frm;
  assign w_ch_last  = w_ch == CWI'(CHANNELS - 1);
  assign w_frm_last = w_frm == FWI'(DECIM - 1);
  assign w_emit     = w_acc && (w_st == EMIT);
  // Frame 0 ignores whatever the accumulator held, so it never needs clearing
  assign w_ext      = ACC_W'($signed(s_data));
  assign w_base     = (w_frm == '0) ? '0 : r_acc[w_ch];
  assign w_sum      = w_base + w_ext;
  assign w_q        = (32'(w_sum) + RND) >>> SH;
  assign w_out      = (w_q > 32767) ? 16'h7fff : (w_q < -32768) ? 16'h8000 : w_q[15:0];

  // State register
  always_ff @(posedge clk or posedge rst)
    if (rst) r_state <= ST0;
    else     r_state <= w_state_nxt;

  // Next state: HOLD times out to idle; accepted samples advance ACCUM->EMIT->HOLD
  always_comb begin
    w_state_nxt = r_state;
    if (r_state == HOLD) w_state_nxt = (r_hold == '0) ? ST0 : HOLD;
    else if (w_acc)
      w_state_nxt = (w_st == EMIT && w_ch_last) ? HOLD :
                    (w_ch_last && w_frm == FWI'(DECIM - 2)) ? EMIT : w_st;
  end

  // Channel/frame counters, hold-off timer and post-reset ready delay
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_ch   <= '0;
      r_frm  <= '0;
      r_hold <= '0;
      r_live <= 1'b0;
    end else begin
      r_live <= 1'b1;
      r_hold <= (r_state != HOLD) ? HWI'(HOLDOFF) : r_hold - 1'b1;
      if (w_acc) begin
        r_ch  <= w_ch_last ? '0 : w_ch + 1'b1;
        r_frm <= w_ch_last ? (w_frm_last ? '0 : w_frm + 1'b1) : w_frm;
      end
    end

  // Per-channel running sums for all but the last frame
  always_ff @(posedge clk)
    if (w_acc && w_st == ACCUM) r_acc[w_ch] <= w_sum;

  // Registered write port and status pulses
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      en         <= 1'b0;
      data_out   <= '0;
      frame_done <= 1'b0;
      sync_err   <= 1'b0;
    end else begin
      en         <= w_emit;
      frame_done <= w_emit && w_ch_last;
      sync_err   <= w_acc && w_resync;
      if (w_emit) data_out <= w_out;
    end
endmodule
